alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Command-side controller for the 4-bit ALU. It accepts operation commands over a valid/ready handshake and drives the ALU's `valid_in`/`a`/`b`/`cin`/`ctl` inputs for exactly one cycle per command. It then captures the ALU's registered `valid_out`/`alu`/`carry`/`zero` response and returns it downstream over a second valid/ready handshake. It owns the architectural carry and zero flag registers that feed `cin` back into carry-chained operations.

## Interface
Parameters:
- `TIMEOUT`, default 4: number of WAIT cycles allowed for `alu_valid_out` before the command is aborted with an error; legal range 1..15.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_op` in 4: ALU opcode, 0..13 legal (SEL, INC, DEC, ADD, ADD_c, SUB, SUB_b, AND, OR, XOR, SHIFT_L, SHIFT_R, ROTATE_L, ROTATE_R).
- `cmd_a` in 4: operand A.
- `cmd_b` in 4: operand B.
- `cmd_use_cf` in 1: 1 = drive `alu_cin` from the carry flag; 0 = drive `alu_cin` = 0.
- `alu_valid_in` out 1: to ALU `valid_in`.
- `alu_a` out 4: to ALU `a`.
- `alu_b` out 4: to ALU `b`.
- `alu_cin` out 1: to ALU `cin`.
- `alu_ctl` out 4: to ALU `ctl`.
- `alu_valid_out` in 1: from ALU.
- `alu_result` in 4: from ALU `alu`.
- `alu_carry` in 1: from ALU `carry`.
- `alu_zero` in 1: from ALU `zero`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: downstream accepts the response.
- `rsp_result` out 4: captured result.
- `rsp_carry` out 1: captured carry.
- `rsp_zero` out 1: captured zero.
- `rsp_err` out 1: 1 = illegal opcode or timeout.
- `cf` out 1: carry flag register.
- `zf` out 1: zero flag register.

## Operation
FSM states are IDLE, ISSUE, WAIT and RESP. All outputs are registered or decoded from state.

- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid`, latch op, a, b, and cin = `cmd_use_cf ? cf : 0`.
  - If `cmd_op` ≥ 14, go to RESP with `rsp_err`=1 and result/carry/zero = 0. The ALU is not issued and the flags are unchanged.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `alu_valid_in` = 1 for exactly this one cycle. `alu_a`/`alu_b`/`alu_ctl`/`alu_cin` carry the latched values.
  - Clear the timer, then go to WAIT.
- **WAIT**
  - If `alu_valid_out` = 1: capture `alu_result`, `alu_carry` and `alu_zero` into the rsp registers with `rsp_err`=0, load `cf`←`alu_carry` and `zf`←`alu_zero`, then go to RESP.
  - Otherwise increment the timer. When TIMEOUT WAIT cycles have elapsed without `alu_valid_out`, go to RESP with `rsp_err`=1 and result/carry/zero = 0. The flags are unchanged.
- **RESP**
  - Hold `rsp_valid`=1 and the rsp fields stable until `rsp_ready`=1, then go to IDLE.
  - `cmd_ready` is 0 in every state except IDLE. There is one command in flight at most.
- **Outside ISSUE:** `alu_valid_in`=0. `alu_a`/`alu_b`/`alu_ctl`/`alu_cin` hold their last values.
- **Stray `alu_valid_out`:** ignored when seen in IDLE, ISSUE or RESP. The flags do not change.
- **Flag updates:** `cf`/`zf` change only on a successful WAIT capture.

## Timing
- **Reset values:** state IDLE, `cmd_ready`=1 (decoded from IDLE), and all other outputs 0, including `cf`, `zf`, `alu_*` and all `rsp_*`.
- **Reset asserted mid-operation:** the in-flight command is discarded with no response, and the flags clear.
- **Nominal latency:** command accepted at edge N, `alu_valid_in` high in cycle N+1, ALU `valid_out` high in N+2, `rsp_valid` high from N+3.
- **Accept-to-accept throughput:** 4 cycles minimum with `rsp_ready` tied high.
- **Timeout:** `rsp_valid` rises at N+2+TIMEOUT.
- **Illegal opcode:** `rsp_valid` rises at N+1.
- **Back-to-back handshakes:** `rsp_ready` completing in cycle M makes `cmd_ready`=1 in cycle M+1. There is no same-cycle response/command bypass.

## Configuration
- **`ALU_ISSUE_STATS_EN` defined:** adds outputs `stat_ops` (16-bit) and `stat_errs` (16-bit). Both reset to 0 and saturate at 0xFFFF.
  - `stat_ops` increments on every accepted command.
  - `stat_errs` increments on every response with `rsp_err`=1.
- **Not defined:** the counters and ports are absent. All other behaviour is identical.

## Test plan
The bench attaches a 1-cycle ALU model unless a scenario says otherwise.
- **Reset:** async `reset` low mid-WAIT → all outputs 0 immediately, `cmd_ready`=1 after release, no response produced.
- **ADD:** ADD a=9 b=8 → `alu_valid_in` pulse of exactly 1 cycle, `rsp_result`=1, `rsp_carry`=1, `cf`=1, `rsp_valid` 3 cycles after accept.
- **Carry chain:** after the ADD above, ADD_c a=1 b=1 `cmd_use_cf`=1 → `alu_cin`=1, `rsp_result`=3, `cf`=0. The same command with `cmd_use_cf`=0 → `alu_cin`=0, `rsp_result`=2.
- **Illegal opcode:** `cmd_op`=14 → no `alu_valid_in` pulse, `rsp_valid` next cycle with `rsp_err`=1 and result 0, `cf`/`zf` unchanged.
- **Timeout:** TIMEOUT=4 with an ALU stub that never asserts `valid_out` → `rsp_err`=1 at accept+6 cycles. A stray `alu_valid_out` in the following IDLE does not change the flags.
- **Backpressure:** `rsp_ready` held low 5 cycles → `rsp_*` stable, `cmd_ready`=0 throughout, `cmd_valid` held. The next command is accepted the cycle after `rsp_ready`.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
// Bundles every handshake and bus signal of alu_issue_ctrl so the controller
// and its environment connect through one port.
//   cmd_*     : command channel (valid/ready), opcode, operands, carry-use select
//   alu_*     : one-cycle issue towards the ALU and its registered response
//   rsp_*     : response channel (valid/ready) with captured result and error
//   cf / zf   : architectural carry and zero flag registers
//   stat_*    : present only when ALU_ISSUE_STATS_EN is defined
// Modport master is the controller side; modport slave is the environment side.
interface alu_issue_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_use_cf;

  logic       alu_valid_in;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic [3:0] alu_ctl;
  logic       alu_valid_out;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_err;

  logic       cf;
  logic       zf;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_errs;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_cf,
    output cmd_ready,
    output alu_valid_in, alu_a, alu_b, alu_cin, alu_ctl,
    input  alu_valid_out, alu_result, alu_carry, alu_zero,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
    input  rsp_ready,
    output cf, zf,
    output stat_ops, stat_errs
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_cf,
    input  cmd_ready,
    input  alu_valid_in, alu_a, alu_b, alu_cin, alu_ctl,
    output alu_valid_out, alu_result, alu_carry, alu_zero,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
    output rsp_ready,
    input  cf, zf,
    input  stat_ops, stat_errs
  );
`else
  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_cf,
    output cmd_ready,
    output alu_valid_in, alu_a, alu_b, alu_cin, alu_ctl,
    input  alu_valid_out, alu_result, alu_carry, alu_zero,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
    input  rsp_ready,
    output cf, zf
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_cf,
    input  cmd_ready,
    input  alu_valid_in, alu_a, alu_b, alu_cin, alu_ctl,
    output alu_valid_out, alu_result, alu_carry, alu_zero,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
    output rsp_ready,
    input  cf, zf
  );
`endif
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Command-side controller for the 4-bit ALU. Accepts one command at a time,
// issues it to the ALU for exactly one cycle, waits (bounded by TIMEOUT) for
// the ALU's registered response, and returns it on the response channel.
// Owns the carry/zero flag registers used to feed alu_cin on chained ops.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : alu_issue_ctrl_if.master (command, ALU, response, flag signals)
// Parameter TIMEOUT (1..15): WAIT cycles allowed before aborting with rsp_err.
// Optional feature macro ALU_ISSUE_STATS_EN adds saturating 16-bit counters
// stat_ops (accepted commands) and stat_errs (error responses).
module alu_issue_ctrl #(
  parameter int unsigned TIMEOUT = 4
) (
  input logic             clk,
  input logic             reset,
  alu_issue_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  // Timer value on the last permitted WAIT cycle.
  localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic [3:0] timer_q, timer_d;
  logic [3:0] rsp_result_q, rsp_result_d;
  logic       rsp_carry_q, rsp_carry_d;
  logic       rsp_zero_q, rsp_zero_d;
  logic       rsp_err_q, rsp_err_d;
  logic       cf_q, cf_d;
  logic       zf_q, zf_d;
  logic       accept;
  logic       err_rsp;

  // Next-state and datapath decode. Every register holds unless the state
  // explicitly updates it, so alu_* operands keep their last values.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    timer_d      = timer_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    cf_d         = cf_q;
    zf_d         = zf_q;
    accept       = 1'b0;
    err_rsp      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          accept = 1'b1;
          op_d   = bus.cmd_op;
          a_d    = bus.cmd_a;
          b_d    = bus.cmd_b;
          cin_d  = bus.cmd_use_cf & cf_q;
          // Opcodes 14 and 15 have no ALU meaning: answer directly with an
          // error and never touch the ALU or the flags.
          if (bus.cmd_op >= 4'd14) begin
            rsp_result_d = 4'd0;
            rsp_carry_d  = 1'b0;
            rsp_zero_d   = 1'b0;
            rsp_err_d    = 1'b1;
            err_rsp      = 1'b1;
            state_d      = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        timer_d = 4'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.alu_valid_out) begin
          rsp_result_d = bus.alu_result;
          rsp_carry_d  = bus.alu_carry;
          rsp_zero_d   = bus.alu_zero;
          rsp_err_d    = 1'b0;
          cf_d         = bus.alu_carry;
          zf_d         = bus.alu_zero;
          state_d      = S_RESP;
        end else if (timer_q == TimeoutLast) begin
          rsp_result_d = 4'd0;
          rsp_carry_d  = 1'b0;
          rsp_zero_d   = 1'b0;
          rsp_err_d    = 1'b1;
          err_rsp      = 1'b1;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= 4'd0;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      cin_q        <= 1'b0;
      timer_q      <= 4'd0;
      rsp_result_q <= 4'd0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      cf_q         <= 1'b0;
      zf_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      timer_q      <= timer_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      cf_q         <= cf_d;
      zf_q         <= zf_d;
    end
  end

  assign bus.cmd_ready    = (state_q == S_IDLE);
  assign bus.alu_valid_in = (state_q == S_ISSUE);
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_cin      = cin_q;
  assign bus.alu_ctl      = op_q;
  assign bus.rsp_valid    = (state_q == S_RESP);
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_carry    = rsp_carry_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.cf           = cf_q;
  assign bus.zf           = zf_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_errs_q, stat_errs_d;

  // Saturating counters: stop at 0xFFFF rather than wrap.
  always_comb begin
    stat_ops_d  = stat_ops_q;
    stat_errs_d = stat_errs_q;
    if (accept && (stat_ops_q != 16'hFFFF)) begin
      stat_ops_d = stat_ops_q + 16'd1;
    end
    if (err_rsp && (stat_errs_q != 16'hFFFF)) begin
      stat_errs_d = stat_errs_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ops_q  <= 16'd0;
      stat_errs_q <= 16'd0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign bus.stat_ops  = stat_ops_q;
  assign bus.stat_errs = stat_errs_q;
`else
  // Without the counters these decodes have no consumer.
  logic unused_stats;
  assign unused_stats = accept ^ err_rsp;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Self-checking bench for alu_issue_ctrl with a 1-cycle ALU model attached.
// Table-driven command vectors plus hand-written sequences for timeout,
// stray ALU responses, mid-WAIT reset and response backpressure.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.TIMEOUT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // ALU model controls: stubSilent suppresses valid_out, strayVo injects one.
  logic       stubSilent = 1'b0;
  logic       strayVo    = 1'b0;
  logic       aluVoQ;
  logic [3:0] aluResQ;
  logic       aluCarryQ;
  logic       aluZeroQ;

  // Reference 4-bit ALU: {carry, result}; carry is borrow for subtractions.
  function automatic logic [4:0] aluFn(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic cin);
    logic [4:0] r;
    case (op)
      4'd0:  r = {1'b0, a};
      4'd1:  r = {1'b0, a} + 5'd1;
      4'd2:  r = {1'b0, a} - 5'd1;
      4'd3:  r = {1'b0, a} + {1'b0, b};
      4'd4:  r = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      4'd5:  r = {1'b0, a} - {1'b0, b};
      4'd6:  r = {1'b0, a} - {1'b0, b} - {4'd0, cin};
      4'd7:  r = {1'b0, a & b};
      4'd8:  r = {1'b0, a | b};
      4'd9:  r = {1'b0, a ^ b};
      4'd10: r = {a[3], a[2:0], 1'b0};
      4'd11: r = {a[0], 1'b0, a[3:1]};
      4'd12: r = {a[3], a[2:0], a[3]};
      4'd13: r = {a[0], a[0], a[3:1]};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      aluVoQ    <= 1'b0;
      aluResQ   <= 4'd0;
      aluCarryQ <= 1'b0;
      aluZeroQ  <= 1'b0;
    end else begin
      aluVoQ <= bus.alu_valid_in & ~stubSilent;
      if (bus.alu_valid_in) begin
        {aluCarryQ, aluResQ} <= aluFn(bus.alu_ctl, bus.alu_a, bus.alu_b, bus.alu_cin);
        aluZeroQ <= (aluFn(bus.alu_ctl, bus.alu_a, bus.alu_b, bus.alu_cin) & 5'h0F) == 5'd0;
      end
    end
  end

  assign bus.alu_valid_out = aluVoQ | strayVo;
  assign bus.alu_result    = aluResQ;
  assign bus.alu_carry     = aluCarryQ;
  assign bus.alu_zero      = aluZeroQ;

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       useCf;
    logic [3:0] expResult;
    logic       expCarry;
    logic       expZero;
    logic       expErr;
    logic       expCin;
    int         expLatency;
    logic       expCf;
    logic       expZf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Present one command and follow it until rsp_valid, tracking the ALU pulse.
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                               input logic useCf, output int latency, output int pulses,
                               output logic pulseCin);
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_a      = a;
    bus.cmd_b      = b;
    bus.cmd_use_cf = useCf;
    check("cmd_ready_idle", 16'(bus.cmd_ready), 16'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    latency  = 1;
    pulses   = 0;
    pulseCin = 1'b0;
    while (!bus.rsp_valid && latency < 40) begin
      if (bus.alu_valid_in) begin
        pulses++;
        pulseCin = bus.alu_cin;
      end
      @(negedge clk);
      latency++;
    end
    if (!bus.rsp_valid) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL rsp_wait_bound: rsp_valid not seen within %0d cycles", latency);
    end
  endtask

  // Complete the response handshake and confirm cmd_ready the next cycle.
  task automatic completeRsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("cmd_ready_after_rsp", 16'(bus.cmd_ready), 16'd1);
    check("rsp_valid_cleared", 16'(bus.rsp_valid), 16'd0);
  endtask

  task automatic checkOutput(input vec_t v, input int latency, input int pulses, input logic pulseCin);
    check("rsp_result", 16'(bus.rsp_result), 16'(v.expResult));
    check("rsp_carry", 16'(bus.rsp_carry), 16'(v.expCarry));
    check("rsp_zero", 16'(bus.rsp_zero), 16'(v.expZero));
    check("rsp_err", 16'(bus.rsp_err), 16'(v.expErr));
    check("latency", 16'(latency), 16'(v.expLatency));
    check("issue_pulses", 16'(pulses), v.expErr ? 16'd0 : 16'd1);
    if (!v.expErr) check("alu_cin", 16'(pulseCin), 16'(v.expCin));
    check("cf", 16'(bus.cf), 16'(v.expCf));
    check("zf", 16'(bus.zf), 16'(v.expZf));
  endtask

  initial begin
    int   lat;
    int   pulses;
    logic pcin;
    int   seenRsp;

    //          op     a      b     useCf res    c     z     err   cin  lat cf    zf
    vecs[0]  = '{4'd3,  4'd9, 4'd8, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0};
    vecs[1]  = '{4'd14, 4'd5, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    vecs[2]  = '{4'd4,  4'd1, 4'd1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0};
    vecs[3]  = '{4'd3,  4'd9, 4'd8, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0};
    vecs[4]  = '{4'd4,  4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[5]  = '{4'd5,  4'd3, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1};
    vecs[6]  = '{4'd15, 4'd7, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1};
    vecs[7]  = '{4'd9,  4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    vecs[8]  = '{4'd10, 4'h9, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0};
    vecs[9]  = '{4'd2,  4'h0, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0};
    vecs[10] = '{4'd1,  4'hF, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1};

    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 4'd0;
    bus.cmd_a      = 4'd0;
    bus.cmd_b      = 4'd0;
    bus.cmd_use_cf = 1'b0;
    bus.rsp_ready  = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", 16'(bus.cmd_ready), 16'd1);
    check("reset_rsp_valid", 16'(bus.rsp_valid), 16'd0);
    check("reset_alu_valid_in", 16'(bus.alu_valid_in), 16'd0);
    check("reset_cf_zf", 16'({bus.cf, bus.zf}), 16'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].useCf, lat, pulses, pcin);
      checkOutput(vecs[i], lat, pulses, pcin);
      completeRsp();
    end

    // Timeout with a silent ALU: flags stay at cf=1, zf=1 from the last vector.
    stubSilent = 1'b1;
    applyStimulus(4'd3, 4'd1, 4'd2, 1'b0, lat, pulses, pcin);
    check("to_latency", 16'(lat), 16'd6);
    check("to_err", 16'(bus.rsp_err), 16'd1);
    check("to_result", 16'(bus.rsp_result), 16'd0);
    check("to_flags", 16'({bus.cf, bus.zf}), 16'b11);
    completeRsp();
    stubSilent = 1'b0;

    // Stray valid_out in IDLE with a zero/no-carry result pending on the bus.
    strayVo = 1'b1;
    @(negedge clk);
    strayVo = 1'b0;
    @(negedge clk);
    check("stray_flags", 16'({bus.cf, bus.zf}), 16'b11);
    check("stray_no_rsp", 16'(bus.rsp_valid), 16'd0);

    // Asynchronous reset while the command sits in WAIT.
    stubSilent     = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 4'd3;
    bus.cmd_a      = 4'd6;
    bus.cmd_b      = 4'd1;
    bus.cmd_use_cf = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_alu_a", 16'(bus.alu_a), 16'd0);
    check("rst_alu_cin", 16'(bus.alu_cin), 16'd0);
    check("rst_flags", 16'({bus.cf, bus.zf}), 16'd0);
    check("rst_rsp", 16'({bus.rsp_valid, bus.rsp_err, bus.rsp_result}), 16'd0);
    @(negedge clk);
    reset      = 1'b1;
    stubSilent = 1'b0;
    @(posedge clk);
    #1;
    check("rst_cmd_ready", 16'(bus.cmd_ready), 16'd1);
    seenRsp = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) seenRsp++;
    end
    check("rst_no_rsp", 16'(seenRsp), 16'd0);

    // Backpressure: response held 5 cycles while the next command waits.
    applyStimulus(4'd3, 4'd2, 4'd3, 1'b0, lat, pulses, pcin);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 4'd7;
    bus.cmd_a      = 4'd7;
    bus.cmd_b      = 4'd3;
    bus.cmd_use_cf = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 16'(bus.rsp_valid), 16'd1);
      check("bp_rsp_result", 16'(bus.rsp_result), 16'd5);
      check("bp_cmd_ready", 16'(bus.cmd_ready), 16'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_cmd_ready_next", 16'(bus.cmd_ready), 16'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("bp_issue", 16'(bus.alu_valid_in), 16'd1);
    check("bp_alu_a", 16'(bus.alu_a), 16'd7);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_next_latency", 16'(lat), 16'd3);
    check("bp_next_result", 16'(bus.rsp_result), 16'd3);
    completeRsp();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
